// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser, first-word-fall-through scan-code
// FIFO and a make/break tracker reporting the current key, held flag and press count.
module ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic       ready,
    output logic [7:0] data,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] cur_key,
    output logic       key_down,
    output logic [7:0] key_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   PTR_INC = (AW + 1)'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_BREAK} key_state_t;

    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] to_cnt;
    logic          rx_done;
    logic [7:0]    rx_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    key_state_t    key_state;

    // Sync flops idle high so reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall = clk_sync[2] & ~clk_sync[1];

    // Bits 0..9 shift in from the top; the stop bit is judged live on the 11th edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            rx_done   <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!shreg[0] && data_sync[1] && (^shreg[9:1])) begin
                        rx_done <= 1'b1;
                        rx_byte <= shreg[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_LAST) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~nextdata_n & ~empty;
    assign push  = rx_done & (~full | pop);
    assign ready = ~empty;
    assign data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_INC;
            if (pop)  rd_ptr <= rd_ptr + PTR_INC;
            if (rx_done && !push) overflow <= 1'b1;
        end
    end

    // Key tracking sees every valid byte, even one the full FIFO dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_state <= ST_IDLE;
            cur_key   <= '0;
            key_down  <= 1'b0;
            key_cnt   <= '0;
        end else if (rx_done) begin
            unique case (key_state)
                ST_IDLE: begin
                    if (rx_byte == 8'hF0) begin
                        key_state <= ST_BREAK;
                    end else if (rx_byte != 8'hE0 && !(key_down && rx_byte == cur_key)) begin
                        cur_key  <= rx_byte;
                        key_down <= 1'b1;
                        key_cnt  <= key_cnt + 8'd1;
                    end
                end
                ST_BREAK: begin
                    if (rx_byte == cur_key) key_down <= 1'b0;
                    key_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: frames are driven bit by bit, expected bytes are
// queued at issue time and a monitor compares them whenever the DUT pops its head.
module tb_ps2_kbd_rx;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 40;
    localparam int unsigned HALF  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       frame_err;
    logic [7:0] cur_key;
    logic       key_down;
    logic [7:0] key_cnt;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .ready(ready), .data(data), .overflow(overflow),
        .frame_err(frame_err), .cur_key(cur_key), .key_down(key_down), .key_cnt(key_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_cycles = 0;
    int          exp_err = 0;
    byte unsigned exp_q[$];
    logic        exp_ovf;
    logic [7:0]  m_key;
    logic [7:0]  m_cnt;
    logic        m_down;
    logic        m_brk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every cycle in which the DUT will pop, its head must match the model queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (frame_err === 1'b1) err_cycles++;
            if (rst === 1'b0 && ready === 1'b1 && nextdata_n === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL fifo_extra: got 0x%0h, expected no entry", data);
                end else begin
                    check("fifo_data", data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        m_key   = 8'h00;
        m_cnt   = 8'h00;
        m_down  = 1'b0;
        m_brk   = 1'b0;
    endfunction

    function automatic void model_key(input logic [7:0] b);
        if (m_brk) begin
            if (b == m_key) m_down = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE0 && !(m_down && b == m_key)) begin
            m_key  = b;
            m_down = 1'b1;
            m_cnt  = m_cnt + 8'd1;
        end
    endfunction

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start. nbits < 11 sends a partial frame.
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits,
                              input bit pop_at, input bit chk_lat);
        logic [10:0] f;
        f[0]   = (kind == 3);
        f[8:1] = b;
        f[9]   = (~^b) ^ (kind == 1);
        f[10]  = (kind != 2);
        if (nbits == 11) begin
            if (kind == 0) begin
                if (exp_q.size() < DEPTH || pop_at) exp_q.push_back(b);
                else exp_ovf = 1'b1;
                model_key(b);
            end else begin
                exp_err++;
            end
        end
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) tick();
            ps2_clk = 1'b0;
            for (int t = 1; t <= int'(HALF); t++) begin
                tick();
                if (i == 10 && pop_at) nextdata_n = (t == 3) ? 1'b0 : 1'b1;
                if (i == 10 && chk_lat && t == 3) check("ready_before_latency", ready, 0);
                if (i == 10 && chk_lat && t == 4) begin
                    check("ready_at_latency", ready, 1);
                    check("data_at_latency", data, b);
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2) tick();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".cur_key"}, cur_key, m_key);
        check({tag, ".key_down"}, key_down, m_down);
        check({tag, ".key_cnt"}, key_cnt, m_cnt);
        check({tag, ".overflow"}, overflow, exp_ovf);
        check({tag, ".frame_err_cycles"}, err_cycles, exp_err);
    endtask

    task automatic pop_some(input int n, output int popped);
        popped = 0;
        for (int k = 0; k < n; k++) begin
            if (ready === 1'b1) begin
                nextdata_n = 1'b0;
                tick();
                nextdata_n = 1'b1;
                tick();
                popped++;
            end
        end
    endtask

    task automatic drain(input string tag);
        int popped;
        int want;
        want = exp_q.size();
        pop_some(DEPTH + 2, popped);
        check({tag, ".entries"}, popped, want);
        check({tag, ".ready_empty"}, ready, 0);
        check({tag, ".model_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        model_reset();
        check({tag, ".ready"}, ready, 0);
        check({tag, ".data"}, data, 0);
        check({tag, ".overflow"}, overflow, 0);
        check({tag, ".frame_err"}, frame_err, 0);
        check({tag, ".cur_key"}, cur_key, 0);
        check({tag, ".key_down"}, key_down, 0);
        check({tag, ".key_cnt"}, key_cnt, 0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        int popped;
        rst        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        model_reset();
        repeat (4) tick();
        do_reset("reset");

        send_frame(8'h1C, 0, 11, 1'b0, 1'b1);
        check_state("first");

        send_frame(8'h1C, 0, 11, 1'b0, 1'b0);
        send_frame(8'hF0, 0, 11, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 11, 1'b0, 1'b0);
        send_frame(8'h32, 0, 11, 1'b0, 1'b0);
        check_state("seq");
        drain("seq_drain");

        send_frame(8'h1C, 1, 11, 1'b0, 1'b0);
        send_frame(8'h1C, 2, 11, 1'b0, 1'b0);
        check_state("bad");
        check("bad.ready", ready, 0);

        for (int i = 0; i < 9; i++) begin
            send_frame(8'($urandom_range(1, 127)), 0, 11, 1'b0, 1'b0);
            if (i >= 7) check_state("fill");
        end
        send_frame(8'h5A, 0, 11, 1'b1, 1'b0);
        check_state("full_pop_push");
        drain("full_drain");

        send_frame(8'h00, 0, 5, 1'b0, 1'b0);
        repeat (TO + 20) tick();
        send_frame(8'h45, 0, 11, 1'b0, 1'b0);
        check_state("timeout");
        drain("timeout_drain");

        send_frame(8'h2A, 0, 11, 1'b0, 1'b0);
        send_frame(8'h00, 0, 5, 1'b0, 1'b0);
        do_reset("mid_reset");
        send_frame(8'h33, 0, 11, 1'b0, 1'b0);
        check_state("after_reset");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hF0;
                2:       b = m_key;
                3:       b = 8'hE0;
                default: b = 8'($urandom);
            endcase
            kind = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
            send_frame(b, kind, 11, 1'b0, 1'b0);
            check_state("rand");
            if ($urandom_range(0, 2) == 0) pop_some(int'($urandom_range(1, 3)), popped);
        end
        drain("rand_drain");

        do_reset("wrap_reset");
        nextdata_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            send_frame((i % 2 == 0) ? 8'h1C : 8'h32, 0, 11, 1'b0, 1'b0);
        end
        send_frame(8'hF0, 0, 11, 1'b0, 1'b0);
        send_frame(8'h32, 0, 11, 1'b0, 1'b0);
        nextdata_n = 1'b1;
        tick();
        check_state("wrap");
        check("wrap.key_cnt_zero", key_cnt, 0);
        check("wrap.key_released", key_down, 0);
        check("wrap.model_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
